// File: rtl/mem_access_pkg.sv
// Shared encodings and helpers for the MEM pipeline stage and its load aligner.
// Holds the memop and state encodings, bus types and lane-select decode.
package mem_access_pkg;

    typedef logic [4:0]  RegAddrBus;
    typedef logic [31:0] RegBus;

    localparam RegAddrBus NOPRegAddr = 5'd0;
    localparam RegBus     ZeroWord   = 32'd0;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Unused encodings 9..15 behave as MEM_NONE so a corrupt op never touches the bus.
    function automatic logic is_memop(input logic [3:0] op);
        return (op != MEM_NONE) && (op <= MEM_SW);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic r;
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: r = lo[0];
            MEM_LW, MEM_SW:          r = (lo != 2'b00);
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    // Big-endian lanes: offset 0 is bits [31:24], which is sel bit 3.
    function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] lo);
        logic [3:0] s;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: s = 4'b1000 >> lo;
            MEM_LH, MEM_LHU, MEM_SH: s = lo[1] ? 4'b0011 : 4'b1100;
            MEM_LW, MEM_SW:          s = 4'b1111;
            default:                 s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Combinational load extractor: picks the addressed byte/half of a big-endian
// bus word and sign- or zero-extends it to 32 bits.
module mem_load_align
    import mem_access_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [3:0]  i_memop,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];
    end

    always_comb begin
        case (i_memop)
            MEM_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            MEM_LBU: o_data = {24'd0, w_byte};
            MEM_LH:  o_data = {{16{w_half[15]}}, w_half};
            MEM_LHU: o_data = {16'd0, w_half};
            MEM_LW:  o_data = i_rdata;
            default: o_data = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: runs loads/stores over a req/ack data bus with timeout, passes
// ALU results through, and drives the write-back triple plus stall request.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_sdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        stallreq,
    output logic        exc_align,
    output logic        exc_bus,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_sel,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata
);

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e      r_state;
    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_sel;
    logic [31:0] r_wdata;
    logic [1:0]  r_off;
    logic [3:0]  r_memop;
    logic        r_load_ok;
    RegBus       r_result;
    logic        r_exc_bus;

    logic        w_is_mem;
    logic        w_misalign;
    logic        w_launch;
    logic [3:0]  w_sel;
    logic [31:0] w_lane_data;
    logic [31:0] w_load_data;

    assign w_is_mem   = is_memop(ex_memop);
    assign w_misalign = is_misaligned(ex_memop, ex_addr[1:0]);
    assign w_launch   = (r_state == ST_IDLE) && w_is_mem && !w_misalign;
    assign w_sel      = lane_sel(ex_memop, ex_addr[1:0]);

    // Replicate the right-aligned store data so every enabled lane carries it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane_data[8*gi +: 8] =
                (ex_memop == MEM_SB) ? ex_sdata[7:0] :
                (ex_memop == MEM_SH) ? ex_sdata[8*(gi%2) +: 8] :
                (ex_memop == MEM_SW) ? ex_sdata[8*gi +: 8] : 8'd0;
        end
    endgenerate

    mem_load_align u_load_align (
        .i_rdata   (dbus_rdata),
        .i_addr_lo (r_off),
        .i_memop   (r_memop),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 8'd0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_sel     <= 4'd0;
            r_wdata   <= 32'd0;
            r_off     <= 2'd0;
            r_memop   <= 4'd0;
            r_load_ok <= 1'b0;
            r_result  <= ZeroWord;
            r_exc_bus <= 1'b0;
        end else begin
            r_exc_bus <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_BUSY;
                        r_cnt   <= 8'd0;
                        r_req   <= 1'b1;
                        r_we    <= is_store(ex_memop);
                        r_addr  <= {ex_addr[31:2], 2'b00};
                        r_sel   <= w_sel;
                        r_wdata <= w_lane_data;
                        r_off   <= ex_addr[1:0];
                        r_memop <= ex_memop;
                    end
                end
                ST_BUSY: begin
                    // An ack on the final allowed cycle wins over the timeout.
                    if (dbus_ack) begin
                        r_state   <= ST_DONE;
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_sel     <= 4'd0;
                        r_load_ok <= !is_store(r_memop);
                        r_result  <= is_store(r_memop) ? ZeroWord : w_load_data;
                    end else if (r_cnt == CntLast) begin
                        r_state   <= ST_DONE;
                        r_req     <= 1'b0;
                        r_we      <= 1'b0;
                        r_sel     <= 4'd0;
                        r_load_ok <= 1'b0;
                        r_result  <= ZeroWord;
                        r_exc_bus <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are gated by rst so an asserted reset silences them before the next edge.
    always_comb begin
        mem_wd    = NOPRegAddr;
        mem_wreg  = 1'b0;
        mem_wdata = ZeroWord;
        stallreq  = 1'b0;
        exc_align = 1'b0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_is_mem) begin
                        mem_wd    = ex_wd;
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end else if (w_misalign) begin
                        exc_align = 1'b1;
                    end else begin
                        stallreq = 1'b1;
                    end
                end
                ST_BUSY: begin
                    stallreq = 1'b1;
                end
                ST_DONE: begin
                    mem_wd    = ex_wd;
                    mem_wreg  = r_load_ok & ex_wreg;
                    mem_wdata = r_result;
                end
                default: begin
                    stallreq = 1'b0;
                end
            endcase
        end
    end

    assign exc_bus    = r_exc_bus;
    assign dbus_req   = r_req;
    assign dbus_we    = r_we;
    assign dbus_addr  = r_addr;
    assign dbus_sel   = r_sel;
    assign dbus_wdata = r_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected write-back results,
// a negedge monitor pops and compares whenever the stage advances.
`timescale 1ns/1ps
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  ex_wd = 5'd7;
    logic        ex_wreg = 1'b1;
    logic [31:0] ex_wdata = 32'h55;
    logic [3:0]  ex_memop = 4'd0;
    logic [31:0] ex_addr = 32'd0;
    logic [31:0] ex_sdata = 32'd0;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq, exc_align, exc_bus;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_sel;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'd0;

    always #5 clk = ~clk;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_sdata(ex_sdata),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .stallreq(stallreq), .exc_align(exc_align), .exc_bus(exc_bus),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        chk_data;
        logic        align;
        logic        bus;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic tb_valid = 1'b0;

    function automatic exp_t mk(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                                input logic chk_data, input logic align, input logic bus);
        exp_t e;
        e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_data = chk_data; e.align = align; e.bus = bus;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && tb_valid && !stallreq) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL monitor_unexpected: got output wd=%0d with empty queue, required none", mem_wd);
            end else begin
                e = exp_q.pop_front();
                chk("wb_wd", 32'(mem_wd), 32'(e.wd));
                chk("wb_wreg", 32'(mem_wreg), 32'(e.wreg));
                if (e.chk_data) chk("wb_wdata", mem_wdata, e.wdata);
                chk("wb_exc_align", 32'(exc_align), 32'(e.align));
                chk("wb_exc_bus", 32'(exc_bus), 32'(e.bus));
                $display("txn t=%0t wd=%0d wreg=%0b wdata=%h align=%0b bus=%0b",
                         $time, mem_wd, mem_wreg, mem_wdata, exc_align, exc_bus);
            end
        end
    end

    // ack_at: BUSY cycle index (0-based) on which ack is driven; -1 never acks.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] wd, input logic [31:0] wdata_in,
                         input int ack_at, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_sel, input logic e_we,
                         input logic [31:0] e_bwdata, input int e_busy, input exp_t e);
        int  nbusy;
        int  nstall;
        bit  done;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ex_memop = op; ex_addr = addr; ex_sdata = sdata; ex_wd = wd;
        ex_wreg = 1'b1; ex_wdata = wdata_in; dbus_rdata = rdata; tb_valid = 1'b1;
        nbusy = 0; nstall = 0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            dbus_ack = 1'b0;
            if (!stallreq) begin
                done = 1'b1;
            end else begin
                nstall++;
                if (dbus_req) begin
                    nbusy++;
                    chk({tag, "_dbus_addr"}, dbus_addr, e_addr);
                    chk({tag, "_dbus_sel"}, 32'(dbus_sel), 32'(e_sel));
                    chk({tag, "_dbus_we"}, 32'(dbus_we), 32'(e_we));
                    chk({tag, "_dbus_wdata"}, dbus_wdata, e_bwdata);
                    if (nbusy == ack_at + 1) dbus_ack = 1'b1;
                end
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_stall_bound: stallreq still 1 after 64 cycles, required release", tag);
        end
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(e_busy));
        chk({tag, "_stall_cycles"}, 32'(nstall), 32'((e_busy == 0) ? 0 : e_busy + 1));
        @(posedge clk); #1;
        tb_valid = 1'b0; ex_memop = MEM_NONE; ex_wreg = 1'b0; dbus_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with live ex_* inputs that must not leak through.
        #3;
        chk("rst_dbus_req", 32'(dbus_req), 32'd0);
        chk("rst_dbus_we", 32'(dbus_we), 32'd0);
        chk("rst_dbus_addr", dbus_addr, 32'd0);
        chk("rst_dbus_sel", 32'(dbus_sel), 32'd0);
        chk("rst_dbus_wdata", dbus_wdata, 32'd0);
        chk("rst_stallreq", 32'(stallreq), 32'd0);
        chk("rst_exc_align", 32'(exc_align), 32'd0);
        chk("rst_exc_bus", 32'(exc_bus), 32'd0);
        chk("rst_mem_wd", 32'(mem_wd), 32'(NOPRegAddr));
        chk("rst_mem_wreg", 32'(mem_wreg), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        #19 rst = 1'b1;

        do_op("pass", MEM_NONE, 32'h0, 32'h0, 5'd3, 32'h1234, -1, 32'h0,
              32'h0, 4'h0, 1'b0, 32'h0, 0, mk(5'd3, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0));
        do_op("lb", MEM_LB, 32'h103, 32'h0, 5'd5, 32'h9999, 0, 32'h112233F0,
              32'h100, 4'b0001, 1'b0, 32'h0, 1, mk(5'd5, 1'b1, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b0));
        do_op("lbu", MEM_LBU, 32'h103, 32'h0, 5'd6, 32'h9999, 0, 32'h112233F0,
              32'h100, 4'b0001, 1'b0, 32'h0, 1, mk(5'd6, 1'b1, 32'h000000F0, 1'b1, 1'b0, 1'b0));
        do_op("lh", MEM_LH, 32'h102, 32'h0, 5'd8, 32'h0, 1, 32'h11228001,
              32'h100, 4'b0011, 1'b0, 32'h0, 2, mk(5'd8, 1'b1, 32'hFFFF8001, 1'b1, 1'b0, 1'b0));
        do_op("lhu", MEM_LHU, 32'h100, 32'h0, 5'd9, 32'h0, 0, 32'h80012233,
              32'h100, 4'b1100, 1'b0, 32'h0, 1, mk(5'd9, 1'b1, 32'h00008001, 1'b1, 1'b0, 1'b0));
        do_op("lw", MEM_LW, 32'h10, 32'h0, 5'd10, 32'h0, 2, 32'hDEADBEEF,
              32'h10, 4'b1111, 1'b0, 32'h0, 3, mk(5'd10, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0));
        do_op("sh", MEM_SH, 32'h202, 32'h0000ABCD, 5'd11, 32'h0, 3, 32'h0,
              32'h200, 4'b0011, 1'b1, 32'hABCDABCD, 4, mk(5'd11, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        do_op("sb", MEM_SB, 32'h301, 32'h1234565A, 5'd12, 32'h0, 0, 32'h0,
              32'h300, 4'b0100, 1'b1, 32'h5A5A5A5A, 1, mk(5'd12, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        do_op("sw", MEM_SW, 32'h400, 32'h01234567, 5'd13, 32'h0, 1, 32'h0,
              32'h400, 4'b1111, 1'b1, 32'h01234567, 2, mk(5'd13, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0));
        do_op("mis_lw", MEM_LW, 32'h101, 32'h0, 5'd14, 32'hAAAA, 0, 32'h0,
              32'h0, 4'h0, 1'b0, 32'h0, 0, mk(NOPRegAddr, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0));
        do_op("mis_sh", MEM_SH, 32'h203, 32'h1, 5'd15, 32'hAAAA, 0, 32'h0,
              32'h0, 4'h0, 1'b0, 32'h0, 0, mk(NOPRegAddr, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0));
        do_op("timeout", MEM_LW, 32'h500, 32'h0, 5'd16, 32'h0, -1, 32'h0,
              32'h500, 4'b1111, 1'b0, 32'h0, 16, mk(5'd16, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1));
        do_op("ack_at_limit", MEM_LW, 32'h600, 32'h0, 5'd17, 32'h0, 15, 32'hCAFEF00D,
              32'h600, 4'b1111, 1'b0, 32'h0, 16, mk(5'd17, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0));

        // Asynchronous reset in the middle of a BUSY access.
        @(posedge clk); #1;
        ex_memop = MEM_LW; ex_addr = 32'h700; ex_wd = 5'd9; ex_wreg = 1'b1;
        @(posedge clk); #3;
        chk("rbusy_req_before", 32'(dbus_req), 32'd1);
        rst = 1'b0; #1;
        chk("rbusy_req_drop", 32'(dbus_req), 32'd0);
        chk("rbusy_stall_drop", 32'(stallreq), 32'd0);
        chk("rbusy_wreg", 32'(mem_wreg), 32'd0);
        ex_memop = MEM_NONE; ex_wreg = 1'b0; ex_wdata = 32'h77;
        #2 rst = 1'b1;
        @(negedge clk); dbus_ack = 1'b1; dbus_rdata = 32'hFFFFFFFF;
        @(negedge clk); dbus_ack = 1'b0;
        chk("late_ack_req", 32'(dbus_req), 32'd0);
        chk("late_ack_stall", 32'(stallreq), 32'd0);
        chk("late_ack_wreg", 32'(mem_wreg), 32'd0);
        chk("late_ack_wdata", mem_wdata, 32'h77);
        @(negedge clk);
        chk("late_ack_wdata2", mem_wdata, 32'h77);

        do_op("post_rst_lb", MEM_LB, 32'h800, 32'h0, 5'd20, 32'h0, 0, 32'h7F000000,
              32'h800, 4'b1000, 1'b0, 32'h0, 1, mk(5'd20, 1'b1, 32'h0000007F, 1'b1, 1'b0, 1'b0));

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM pipeline stage of the 5-stage core: sits between the EX/MEM register and the MEM/WB register.
- Executes loads and stores over a req/ack data bus; passes ALU results straight through.
- Produces the write-back triple (mem_wd, mem_wreg, mem_wdata) and a stall request for the pipeline controller.

Parameters:
- TIMEOUT, 16, maximum BUSY cycles to wait for dbus_ack before aborting with a bus error (range 2..255).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_wd  in  5  destination register address.
- ex_wreg  in  1  register write enable.
- ex_wdata  in  32  ALU result; used for non-memory ops.
- ex_memop  in  4  memory op: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
- ex_addr  in  32  effective byte address.
- ex_sdata  in  32  store data, right-aligned.
- mem_wd  out  5  to MEM/WB.
- mem_wreg  out  1  to MEM/WB.
- mem_wdata  out  32  to MEM/WB.
- stallreq  out  1  freeze EX/MEM and upstream stages.
- exc_align  out  1  misaligned access, single-cycle pulse.
- exc_bus  out  1  bus timeout, single-cycle pulse.
- dbus_req  out  1  access request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word address, bits [1:0] = 0.
- dbus_sel  out  4  byte lanes; bit 3 = bits [31:24].
- dbus_wdata  out  32  lane-replicated store data.
- dbus_ack  in  1  access complete; rdata valid in the same cycle.
- dbus_rdata  in  32  read word.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, timeout counter = 0, result register = 0.
  - All dbus outputs 0; stallreq, exc_align and exc_bus = 0.
  - mem_wd = NOPRegAddr, mem_wreg = 0, mem_wdata = 0.
  - Reset asserted mid-access drops dbus_req immediately; a late ack after reset is ignored.
- Byte order is big-endian. addr[1:0]=0 selects bits [31:24].
  - Byte sel = 4'b1000 >> addr[1:0].
  - Half sel = 4'b1100 for addr[1]=0, 4'b0011 for addr[1]=1.
  - Word sel = 4'b1111.
- Store data is replicated across lanes: SB uses {4{b}}, SH uses {2{h}}.
- Alignment rule: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0.
- IDLE, memop = NONE: combinational pass-through (mem_* = ex_*), stallreq = 0, zero latency.
- IDLE, misaligned mem op:
  - No bus access is issued.
  - exc_align pulses for one cycle.
  - Outputs a bubble (wd = NOPRegAddr, wreg = 0, wdata = 0), stallreq = 0.
  - State stays IDLE.
- IDLE, aligned mem op:
  - Register the bus address, sel, we and wdata; go to BUSY.
  - stallreq = 1 combinationally this cycle; outputs are a bubble.
- BUSY:
  - dbus_req = 1; bus outputs held stable; stallreq = 1; outputs are a bubble; counter increments.
  - On dbus_ack: drop req next cycle, latch the extracted load data into the result register, go to DONE.
  - Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW takes the full word.
  - If counter reaches TIMEOUT-1 without ack: drop req, pulse exc_bus, go to DONE with the write suppressed.
- DONE, lasting exactly one cycle:
  - stallreq = 0, mem_wd = ex_wd.
  - Load: mem_wreg = ex_wreg, mem_wdata = result register.
  - Store or timeout: mem_wreg = 0.
  - Go to IDLE unconditionally. The still-present ex_* op is not re-launched, because upstream advances at the end of this cycle.
- Simultaneous events:
  - An ack arriving in the same cycle the timeout is reached counts as success.
  - An ack received while IDLE or DONE is ignored.
- Total load/store latency = 2 + (cycles until ack): 3 stall-free cycles minimum with a zero-wait ack.

Decomposition:
- Shared defines package holds:
  - the memop encodings (MEM_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8);
  - the state encodings (IDLE/BUSY/DONE);
  - RegAddrBus, RegBus, NOPRegAddr, ZeroWord.
- One natural sub-module: mem_load_align, combinational. Inputs are rdata, addr[1:0] and memop; output is the 32-bit extended result. It is unit-tested separately.

Test Plan:
- Pass-through: memop=NONE, ex_wd=5'd3, ex_wreg=1, ex_wdata=32'h1234 -> same cycle mem_wd=3, mem_wreg=1, mem_wdata=32'h1234, stallreq=0, dbus_req never asserted.
- LB sign-extend: addr=32'h103, rdata=32'h112233F0, ack on 1st BUSY cycle -> dbus_addr=32'h100, sel=4'b0001, stallreq high 2 cycles, then DONE with mem_wdata=32'hFFFFFFF0, wreg=1. Repeat with LBU -> 32'h000000F0.
- SH store: addr=32'h202, sdata=32'h0000ABCD, ack after 3 wait cycles -> dbus_we=1, sel=4'b0011, wdata=32'hABCDABCD held stable until ack; DONE with mem_wreg=0.
- Misaligned LW at addr=32'h101 -> exc_align single pulse, dbus_req stays 0, bubble output, stallreq=0.
- Timeout: LW with ack never asserted, TIMEOUT=16 -> req high exactly 16 cycles, then exc_bus pulses once, DONE with wreg=0, back to IDLE.
- Reset mid-BUSY: drive rst=0 asynchronously between edges -> dbus_req and stallreq fall immediately; after release, state is IDLE and a subsequent ack produces no write.
